// File: rtl/pipeline_sequencer.sv
// Execution controller: gates pipeline advance from host run/step/stop
// commands, drains the pipeline on HALT and counts enabled cycles.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_cmd_valid, i_cmd[1:0] (00 nop, 01 run, 10 step, 11 stop/clear), o_cmd_ready
//   i_fetched_opcode    opcode of the instruction in IF/ID
//   o_pipe_enable       registered pipeline advance
//   o_busy, o_step_done, o_halted, o_cycle_count
module pipeline_sequencer #(
  parameter int                   NB_OPCODE      = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE    = 6'b111111,
  parameter int                   N_DRAIN_STAGES = 4,
  parameter int                   NB_CYCLE_CNT   = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  input  logic [1:0]              i_cmd,
  output logic                    o_cmd_ready,
  input  logic [NB_OPCODE-1:0]    i_fetched_opcode,
  output logic                    o_pipe_enable,
  output logic                    o_busy,
  output logic                    o_step_done,
  output logic                    o_halted,
  output logic [NB_CYCLE_CNT-1:0] o_cycle_count
);

  localparam int NB_DRAIN =
    (N_DRAIN_STAGES > 0) ? $clog2(N_DRAIN_STAGES + 1) : 1;

  localparam logic [NB_DRAIN-1:0] DRAIN_INIT =
    NB_DRAIN'(N_DRAIN_STAGES);
  localparam logic [NB_DRAIN-1:0] DRAIN_ONE = NB_DRAIN'(1);
  localparam logic [NB_CYCLE_CNT-1:0] CNT_ONE = NB_CYCLE_CNT'(1);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;

  logic cmd_fire;
  logic is_run, is_step, is_stop;
  logic halt_seen;

  logic pipe_en_d, busy_d, halted_d, step_done_d, cnt_clr;

  assign o_cmd_ready = (state_q == S_IDLE) ||
                       (state_q == S_RUN)  ||
                       (state_q == S_HALTED);

  assign cmd_fire = i_cmd_valid & o_cmd_ready;
  assign is_run   = cmd_fire & (i_cmd == CMD_RUN);
  assign is_step  = cmd_fire & (i_cmd == CMD_STEP);
  assign is_stop  = cmd_fire & (i_cmd == CMD_STOP);

  // Opcode only matters while the pipeline actually advances.
  assign halt_seen = o_pipe_enable &
                     (i_fetched_opcode == HALT_OPCODE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_run:  state_d = S_RUN;
          is_step: state_d = S_STEP;
          default: state_d = S_IDLE;
        endcase
      end
      S_RUN: begin
        // HALT beats a simultaneous stop; the stop is dropped.
        if (halt_seen) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else if (is_stop) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (halt_seen) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      S_HALTED: begin
        if (is_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so a
  // command accepted at an edge takes effect in the following cycle.
  always_comb begin
    pipe_en_d   = (state_d == S_RUN)  ||
                  (state_d == S_STEP) ||
                  ((state_d == S_DRAIN) && (drain_d != '0));
    busy_d      = (state_d == S_RUN)  ||
                  (state_d == S_STEP) ||
                  (state_d == S_DRAIN);
    halted_d    = (state_d == S_HALTED);
    step_done_d = (state_q == S_STEP) && (state_d == S_IDLE);
    cnt_clr     = (state_q == S_HALTED) && (state_d == S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_pipe_enable <= 1'b0;
      o_busy        <= 1'b0;
      o_step_done   <= 1'b0;
      o_halted      <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_pipe_enable <= pipe_en_d;
      o_busy        <= busy_d;
      o_step_done   <= step_done_d;
      o_halted      <= halted_d;
      if (cnt_clr) begin
        o_cycle_count <= '0;
      end else if (o_pipe_enable && (o_cycle_count != '1)) begin
        o_cycle_count <= o_cycle_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios plus random commands,
// checked against a behavioural model; a second instance covers N=0.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid;
  logic [1:0]  cmd;
  logic [5:0]  op;
  logic        ready, en, busy, sdone, halted;
  logic [31:0] cnt;

  logic        z_valid;
  logic [1:0]  z_cmd;
  logic [5:0]  z_op;
  logic        z_ready, z_en, z_busy, z_sdone, z_halted;
  logic [2:0]  z_cnt;

  pipeline_sequencer dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_cmd_valid      (valid),
    .i_cmd            (cmd),
    .o_cmd_ready      (ready),
    .i_fetched_opcode (op),
    .o_pipe_enable    (en),
    .o_busy           (busy),
    .o_step_done      (sdone),
    .o_halted         (halted),
    .o_cycle_count    (cnt)
  );

  pipeline_sequencer #(
    .N_DRAIN_STAGES (0),
    .NB_CYCLE_CNT   (3)
  ) dz (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_cmd_valid      (z_valid),
    .i_cmd            (z_cmd),
    .o_cmd_ready      (z_ready),
    .i_fetched_opcode (z_op),
    .o_pipe_enable    (z_en),
    .o_busy           (z_busy),
    .o_step_done      (z_sdone),
    .o_halted         (z_halted),
    .o_cycle_count    (z_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_DRN  = 3;
  localparam int M_HLT  = 4;

  int     m_mode;
  int     m_left;
  longint m_cnt;
  bit     m_en;
  bit     m_sdone;

  logic       rv;
  logic [1:0] rc;
  logic [5:0] ro;

  task automatic m_reset();
    m_mode  = M_IDLE;
    m_left  = 0;
    m_cnt   = 0;
    m_en    = 0;
    m_sdone = 0;
  endtask

  function automatic bit m_ready();
    return (m_mode == M_IDLE) || (m_mode == M_RUN) ||
           (m_mode == M_HLT);
  endfunction

  task automatic m_edge(bit v, logic [1:0] c, logic [5:0] o);
    bit fire;
    bit hit;
    fire = v && m_ready();
    hit  = m_en && (o == 6'h3f);
    if (m_en && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    m_sdone = 0;
    case (m_mode)
      M_IDLE: begin
        if (fire && c == 2'd1) m_mode = M_RUN;
        if (fire && c == 2'd2) m_mode = M_STEP;
      end
      M_RUN: begin
        if (hit) begin
          m_mode = M_DRN;
          m_left = 4;
        end else if (fire && c == 2'd3) begin
          m_mode = M_IDLE;
        end
      end
      M_STEP: begin
        if (hit) begin
          m_mode = M_DRN;
          m_left = 4;
        end else begin
          m_mode  = M_IDLE;
          m_sdone = 1;
        end
      end
      M_DRN: begin
        if (m_left == 0) m_mode = M_HLT;
        else m_left--;
      end
      default: begin
        if (fire && c == 2'd3) begin
          m_mode = M_IDLE;
          m_cnt  = 0;
        end
      end
    endcase
    m_en = (m_mode == M_RUN) || (m_mode == M_STEP) ||
           (m_mode == M_DRN && m_left > 0);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("en",     {31'd0, en},     {31'd0, m_en});
    chk("cnt",    cnt,             m_cnt[31:0]);
    chk("busy",   {31'd0, busy},
        {31'd0, m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRN});
    chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HLT});
    chk("sdone",  {31'd0, sdone},  {31'd0, m_sdone});
    chk("ready",  {31'd0, ready},  {31'd0, m_ready()});
  endtask

  task automatic cyc(bit v, logic [1:0] c, logic [5:0] o);
    valid = v;
    cmd   = c;
    op    = o;
    @(posedge clk);
    m_edge(v, c, o);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    valid = 0;
    cmd   = 0;
    op    = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    m_reset();
  endtask

  initial begin
    rst_n   = 0;
    valid   = 1;
    cmd     = 2'd1;
    op      = 0;
    z_valid = 0;
    z_cmd   = 0;
    z_op    = 0;
    m_reset();

    // reset held with a run command pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en",     {31'd0, en},     32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_sdone",  {31'd0, sdone},  32'd0);
    chk("rst_cnt",    cnt,             32'd0);
    chk("rst_ready",  {31'd0, ready},  32'd1);
    do_reset();

    // run, then pause and resume
    cyc(1, 2'd1, 0);
    chk("run_en", {31'd0, en}, 32'd1);
    chk("run_c0", cnt, 32'd0);
    cyc(0, 0, 0);
    chk("run_c1", cnt, 32'd1);
    cyc(0, 0, 0);
    chk("run_c2", cnt, 32'd2);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 2'd3, 0);
    chk("pause_en", {31'd0, en}, 32'd0);
    chk("pause_c",  cnt, 32'd6);
    cyc(0, 0, 0);
    chk("pause_hold", cnt, 32'd6);
    cyc(1, 2'd1, 0);
    cyc(0, 0, 0);
    chk("resume_c", cnt, 32'd7);

    // single steps, run ignored while stepping
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'd2, 0);
      chk("step_ready", {31'd0, ready}, 32'd0);
      cyc(1, 2'd1, 0);
      chk("step_done", {31'd0, sdone}, 32'd1);
      chk("step_en",   {31'd0, en},    32'd0);
    end
    chk("step_cnt", cnt, 32'd3);

    // HALT on the 10th enabled cycle
    do_reset();
    cyc(1, 2'd1, 0);
    repeat (9) cyc(0, 0, 0);
    cyc(0, 0, 6'h3f);
    repeat (4) cyc(0, 0, 6'h3f);
    chk("drain_en",  {31'd0, en}, 32'd0);
    chk("drain_cnt", cnt, 32'd14);
    cyc(0, 0, 0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    cyc(1, 2'd1, 0);
    chk("halt_run_en", {31'd0, en}, 32'd0);
    chk("halt_cnt",    cnt, 32'd14);
    cyc(1, 2'd3, 0);
    chk("clear_cnt", cnt, 32'd0);

    // stop and HALT together
    cyc(1, 2'd1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 2'd3, 6'h3f);
    chk("coll_busy", {31'd0, busy}, 32'd1);
    repeat (5) cyc(0, 0, 0);
    chk("coll_halt", {31'd0, halted}, 32'd1);
    chk("coll_cnt",  cnt, 32'd7);
    cyc(1, 2'd3, 0);
    chk("coll_clr",  cnt, 32'd0);
    chk("coll_hclr", {31'd0, halted}, 32'd0);

    // async reset in the middle of a drain
    cyc(1, 2'd1, 0);
    cyc(0, 0, 6'h3f);
    cyc(0, 0, 0);
    rst_n = 0;
    #1;
    chk("areset_en",   {31'd0, en},   32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_cnt",  cnt, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("areset_hold", {31'd0, en}, 32'd0);
    rst_n = 1;
    m_reset();

    // zero drain stages and counter saturation
    z_valid = 1;
    z_cmd   = 2'd1;
    @(posedge clk);
    @(negedge clk);
    z_valid = 0;
    chk("z_run_en", {31'd0, z_en}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("z_sat", {29'd0, z_cnt}, 32'd7);
    z_op = 6'h3f;
    @(posedge clk);
    @(negedge clk);
    z_op = 0;
    chk("z_drain_en",   {31'd0, z_en},   32'd0);
    chk("z_drain_busy", {31'd0, z_busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("z_halt", {31'd0, z_halted}, 32'd1);
    chk("z_cnt",  {29'd0, z_cnt}, 32'd7);
    z_valid = 1;
    z_cmd   = 2'd3;
    @(posedge clk);
    @(negedge clk);
    z_valid = 0;
    chk("z_clr", {29'd0, z_cnt}, 32'd0);

    // random commands and opcodes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 1));
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ro = 6'h3f;
      else ro = 6'($urandom_range(0, 62));
      cyc(rv, rc, ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
